// File: rtl/switch_pkg.sv
// Shared types and constants for the chess-clock player switch.
package switch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUN_P1  = 2'b01,
        RUN_P2  = 2'b10,
        STOPPED = 2'b11
    } switch_state_t;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/sync2.sv
// Purpose: 1-bit multi-flop synchronizer with synchronous clear.
// Latency: SYNC_STAGES cycles from d to q.
// Backpressure: none; free-running, clear forces every stage to 0.
import switch_pkg::*;

module sync2 (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] stages;

    always_ff @(posedge clk) begin
        if (clr) begin
            stages <= '0;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/player_switch.sv
// Purpose: chess-clock turn selector driving one-hot per-player count enables.
// Latency: 1 cycle input-to-output; 3 cycles with SWITCH_SYNC_INPUTS_EN defined.
// Backpressure: none; CLR > CE=0 > STOP > SELECT override the selection every cycle.
import switch_pkg::*;

module player_switch (
    input  logic CLK,
    input  logic CLR,
    input  logic CE,
    input  logic SELECT,
    input  logic STOP,
    output logic Enable_p1,
    output logic Enable_p2
);

    logic          ce_s;
    logic          select_s;
    logic          stop_s;
    switch_state_t state;
    switch_state_t state_nxt;

`ifdef SWITCH_SYNC_INPUTS_EN
    sync2 u_sync_ce (
        .clk (CLK),
        .clr (CLR),
        .d   (CE),
        .q   (ce_s)
    );

    sync2 u_sync_select (
        .clk (CLK),
        .clr (CLR),
        .d   (SELECT),
        .q   (select_s)
    );

    sync2 u_sync_stop (
        .clk (CLK),
        .clr (CLR),
        .d   (STOP),
        .q   (stop_s)
    );
`else
    assign ce_s     = CE;
    assign select_s = SELECT;
    assign stop_s   = STOP;
`endif

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Priority is independent of the current state, so every code recovers in one cycle.
    always_comb begin
        state_nxt = IDLE;
        if (!ce_s) begin
            state_nxt = IDLE;
        end else if (stop_s) begin
            state_nxt = STOPPED;
        end else if (!select_s) begin
            state_nxt = RUN_P1;
        end else begin
            state_nxt = RUN_P2;
        end
    end

    always_comb begin
        Enable_p1 = 1'b0;
        Enable_p2 = 1'b0;
        case (state)
            RUN_P1:  Enable_p1 = 1'b1;
            RUN_P2:  Enable_p2 = 1'b1;
            default: begin
                Enable_p1 = 1'b0;
                Enable_p2 = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_player_switch.sv
// Randomized scoreboard bench for player_switch; reference model applies the
// override priority to inputs delayed by the configured synchronizer depth.
module tb_player_switch;

    logic CLK = 1'b0;
    logic CLR = 1'b0;
    logic CE = 1'b0;
    logic SELECT = 1'b0;
    logic STOP = 1'b0;
    logic Enable_p1;
    logic Enable_p2;

    int checks = 0;
    int passed = 0;

    typedef struct packed {
        logic ce;
        logic stop;
        logic sel;
    } in_t;

    typedef struct packed {
        logic p1;
        logic p2;
    } exp_t;

    exp_t exp_q[$];
    in_t  hist[$];

`ifdef SWITCH_SYNC_INPUTS_EN
    localparam int DELAY = 2;
`else
    localparam int DELAY = 0;
`endif

    player_switch dut (
        .CLK       (CLK),
        .CLR       (CLR),
        .CE        (CE),
        .SELECT    (SELECT),
        .STOP      (STOP),
        .Enable_p1 (Enable_p1),
        .Enable_p2 (Enable_p2)
    );

    always #5 CLK = ~CLK;

    function automatic exp_t decide(input logic clr, input in_t x);
        exp_t e;
        e = '0;
        if (clr || !x.ce || x.stop) e = '0;
        else if (!x.sel)            e = '{p1: 1'b1, p2: 1'b0};
        else                        e = '{p1: 1'b0, p2: 1'b1};
        return e;
    endfunction

    // Applies one cycle of inputs and records what the counters should see after that edge.
    task automatic drive(input logic clr, input logic ce, input logic sel, input logic stop);
        in_t cur;
        in_t seen;
        @(negedge CLK);
        CLR = clr;
        CE = ce;
        SELECT = sel;
        STOP = stop;
        @(posedge CLK);
        cur = '{ce: ce, stop: stop, sel: sel};
        if (DELAY == 0) begin
            seen = cur;
        end else begin
            seen = hist.pop_front();
            hist.push_back(cur);
            if (clr) begin
                hist.delete();
                for (int i = 0; i < DELAY; i++) hist.push_back('0);
            end
        end
        exp_q.push_back(decide(clr, seen));
    endtask

    always begin
        exp_t e;
        @(posedge CLK);
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (Enable_p1 === e.p1 && Enable_p2 === e.p2) begin
                passed++;
            end else begin
                $display("FAIL enables check %0d: got p1=%b p2=%b, expected p1=%b p2=%b",
                         checks, Enable_p1, Enable_p2, e.p1, e.p2);
            end
        end
    end

    initial begin
        for (int i = 0; i < DELAY; i++) hist.push_back('0);

        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        drive(0, 1, 0, 0);
        drive(0, 1, 1, 0);
        drive(0, 1, 1, 1);
        drive(0, 1, 1, 0);
        drive(0, 1, 1, 1);
        drive(0, 0, 1, 0);
        drive(0, 0, 1, 0);
        drive(0, 1, 0, 0);
        drive(0, 1, 0, 0);
        drive(1, 1, 0, 0);
        drive(0, 1, 0, 0);
        drive(0, 1, 0, 0);
        drive(1, 1, 1, 1);
        drive(0, 0, 1, 1);
        for (int i = 0; i < 24; i++) drive(0, 1, i[0], 0);
        for (int i = 0; i < 4; i++) drive(0, 1, 0, 0);

        for (int i = 0; i < 1500; i++) begin
            drive(($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 9) != 0),
                  1'($urandom),
                  ($urandom_range(0, 5) == 0));
        end

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge CLK);
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d expected results never compared, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
